uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_if.sv | 25 ++
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_tx.sv | 162 ++++++++++++++++
 tb/tb_uart_tx.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling, config register map, transmitter states
// and the parity helper used when a byte is accepted.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int CTRL_W     = 3;

  localparam logic [3:0] ADDR_CTRL  = 4'h0;
  localparam logic [3:0] ADDR_PRESC = 4'h1;

  localparam int CTRL_PAR_EN   = 0;
  localparam int CTRL_PAR_ODD  = 1;
  localparam int CTRL_TWO_STOP = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Handshake bundle of the UART transmitter: configuration bus, byte input and
// serial/status outputs. The master side drives bytes and config writes.
interface uart_tx_if;

  logic [3:0] c_addr;
  logic [7:0] c_data;
  logic       c_valid;
  logic       c_ready;
  logic [7:0] data;
  logic       valid_in;
  logic       ready_out;
  logic       tx;
  logic       busy;

  modport master (
    output c_addr, c_data, c_valid, data, valid_in,
    input  c_ready, ready_out, tx, busy
  );

  modport slave (
    input  c_addr, c_data, c_valid, data, valid_in,
    output c_ready, ready_out, tx, busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Baud prescaler: while enabled, pulses tick for one clock every presc_i+1 clocks.
// A synchronous clear restarts the count so a new frame begins on a full period.
module uart_baud_tick #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {PRESC_W{1'b0}};
    end else if (en_i) begin
      if (cnt_q == presc_i) begin
        cnt_d = {PRESC_W{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {PRESC_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == presc_i);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2
// stop bits, each bit OVERSAMPLE baud ticks long. Config writes only land in IDLE.
module uart_tx #(
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int PRESC_W    = 8
) (
  input logic      clk,
  input logic      rst_n,
  uart_tx_if.slave bus
);

  import uart_pkg::*;

  localparam int                TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  tx_state_t           state_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [CTRL_W-1:0]   ctrl_d;
  logic [PRESC_W-1:0]  presc_q;
  logic [PRESC_W-1:0]  presc_d;
  logic [7:0]          shift_q;
  logic                par_q;
  logic [TICK_W-1:0]   tick_cnt_q;
  logic [2:0]          bit_cnt_q;
  logic                stop_cnt_q;
  logic                tx_q;
  logic                busy_q;
  logic                rdy_q;
  logic                cfg_wr;
  logic                accept;
  logic                tick;
  logic                bit_end;

  assign cfg_wr  = bus.c_valid  && rdy_q;
  assign accept  = bus.valid_in && rdy_q;
  assign bit_end = tick && (tick_cnt_q == TICK_LAST);

  // ctrl_d feeds the parity computed at accept, so a same-cycle CTRL write applies to this frame
  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    if (cfg_wr) begin
      case (bus.c_addr)
        ADDR_CTRL:  ctrl_d  = bus.c_data[CTRL_W-1:0];
        ADDR_PRESC: presc_d = bus.c_data[PRESC_W-1:0];
        default:    ctrl_d  = ctrl_q;
      endcase
    end else begin
      ctrl_d  = ctrl_q;
      presc_d = presc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q  <= {CTRL_W{1'b0}};
      presc_q <= {PRESC_W{1'b0}};
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
    end
  end

  uart_baud_tick #(.PRESC_W(PRESC_W)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (accept),
    .en_i    (busy_q),
    .presc_i (presc_q),
    .tick_o  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      tick_cnt_q <= {TICK_W{1'b0}};
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      if (accept) begin
        tick_cnt_q <= {TICK_W{1'b0}};
      end else if (tick) begin
        tick_cnt_q <= tick_cnt_q + {{(TICK_W-1){1'b0}}, 1'b1};
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= START;
            shift_q    <= bus.data;
            par_q      <= parity_bit(bus.data, ctrl_d[CTRL_PAR_ODD]);
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            rdy_q      <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= 3'd0;
              if (ctrl_q[CTRL_PAR_EN]) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (ctrl_q[CTRL_TWO_STOP] && !stop_cnt_q) begin
              stop_cnt_q <= 1'b1;
            end else begin
              stop_cnt_q <= 1'b0;
              state_q    <= IDLE;
              tx_q       <= 1'b1;
              busy_q     <= 1'b0;
              rdy_q      <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.ready_out = rdy_q;
  assign bus.c_ready   = rdy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of frame formats, hand-written corner sequences and
// random frames, all checked against a bit-index model of the serial line.
module tb_uart_tx;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if bus();

  uart_tx #(.OVERSAMPLE(16), .PRESC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int         n_pass  = 0;
  int         n_total = 0;
  logic [2:0] m_ctrl  = 3'd0;
  logic [7:0] m_presc = 8'd0;

  typedef struct {
    logic [7:0] d;
    logic [7:0] ctrl;
    logic [7:0] presc;
    int         exp_len;
    logic       has_par;
    logic       exp_par;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Line level k clocks after accept: bit index k/blen of start,d0..d7,[parity],stop...
  function automatic logic model_bit(input logic [7:0] d, input logic [2:0] ctrl,
                                     input int k, input int blen);
    int idx;
    idx = k / blen;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (ctrl[0] && idx == 9) return (^d) ^ ctrl[1];
    return 1'b1;
  endfunction

  function automatic int model_frame(input logic [2:0] ctrl, input logic [7:0] presc);
    return (10 + int'(ctrl[0]) + int'(ctrl[2])) * 16 * (int'(presc) + 1);
  endfunction

  task automatic wait_ready(input string nm);
    int t;
    t = 0;
    while (bus.ready_out !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_ready"}, {31'd0, bus.ready_out}, 32'd1);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] dd);
    int t;
    bus.c_addr  = a;
    bus.c_data  = dd;
    bus.c_valid = 1'b1;
    t = 0;
    while (bus.c_ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("cfg_ready", {31'd0, bus.c_ready}, 32'd1);
    @(negedge clk);
    bus.c_valid = 1'b0;
    if (a == 4'h0) m_ctrl = dd[2:0];
    else if (a == 4'h1) m_presc = dd;
  endtask

  // Called on the first negedge after accept; optionally raises a config write at cfg_at.
  task automatic check_frame(input string nm, input logic [7:0] d, input int cfg_at,
                             input logic [3:0] ca, input logic [7:0] cd,
                             output int len, output logic par_seen, output int crdy_hi);
    int blen, bad, k;
    blen     = 16 * (int'(m_presc) + 1);
    bad      = 0;
    crdy_hi  = 0;
    par_seen = 1'b0;
    k        = 0;
    while (bus.busy === 1'b1 && k < 4000) begin
      if (k == cfg_at) begin
        bus.c_addr  = ca;
        bus.c_data  = cd;
        bus.c_valid = 1'b1;
      end
      if (bus.tx !== model_bit(d, m_ctrl, k, blen) || bus.ready_out !== 1'b0) bad++;
      if (bus.c_ready !== 1'b0) crdy_hi++;
      if (k == 9 * blen + blen / 2) par_seen = bus.tx;
      k++;
      @(negedge clk);
    end
    len = k;
    chk({nm, "_wave_bad_clks"}, bad, 0);
    chk({nm, "_len"}, len, model_frame(m_ctrl, m_presc));
    chk({nm, "_idle_tx_busy_rdy"}, {29'd0, bus.tx, bus.busy, bus.ready_out}, 32'd5);
  endtask

  task automatic send_frame(input string nm, input logic [7:0] d,
                            output int len, output logic par_seen);
    int crh;
    wait_ready(nm);
    bus.data     = d;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    check_frame(nm, d, -1, 4'h0, 8'h00, len, par_seen, crh);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         len, crh;
    logic       par;
    logic [7:0] rd;

    vt[0] = '{8'hA5, 8'h00, 8'd0, 160, 1'b0, 1'b0};
    vt[1] = '{8'h07, 8'h01, 8'd0, 176, 1'b1, 1'b1};
    vt[2] = '{8'h07, 8'h03, 8'd0, 176, 1'b1, 1'b0};
    vt[3] = '{8'h00, 8'h04, 8'd3, 704, 1'b0, 1'b0};

    bus.c_addr   = 4'h0;
    bus.c_data   = 8'h00;
    bus.c_valid  = 1'b0;
    bus.data     = 8'h00;
    bus.valid_in = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx_busy_rdy_crdy",
        {28'd0, bus.tx, bus.busy, bus.ready_out, bus.c_ready}, 32'd11);
    rst_n = 1'b1;
    @(negedge clk);

    // Test-plan frame formats
    for (int i = 0; i < 4; i++) begin
      cfg_write(4'h0, vt[i].ctrl);
      cfg_write(4'h1, vt[i].presc);
      send_frame($sformatf("vec%0d", i), vt[i].d, len, par);
      chk($sformatf("vec%0d_len_const", i), len, vt[i].exp_len);
      if (vt[i].has_par) chk($sformatf("vec%0d_parity", i), {31'd0, par}, {31'd0, vt[i].exp_par});
    end

    // Back-to-back with valid_in held high
    cfg_write(4'h0, 8'h00);
    cfg_write(4'h1, 8'h00);
    wait_ready("b2b");
    bus.data     = 8'h55;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.data = 8'hAA;
    check_frame("b2b_first", 8'h55, -1, 4'h0, 8'h00, len, par, crh);
    @(negedge clk);
    chk("b2b_second_started", {30'd0, bus.tx, bus.ready_out}, 32'd0);
    bus.valid_in = 1'b0;
    check_frame("b2b_second", 8'hAA, -1, 4'h0, 8'h00, len, par, crh);

    // Config write raised mid-frame is held off until IDLE
    wait_ready("cfgbusy");
    bus.data     = 8'h3C;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    check_frame("cfgbusy", 8'h3C, 50, 4'h1, 8'd2, len, par, crh);
    chk("cfgbusy_cready_low_clks", crh, 0);
    chk("cfgbusy_cready_idle", {31'd0, bus.c_ready}, 32'd1);
    @(negedge clk);
    bus.c_valid = 1'b0;
    m_presc     = 8'd2;
    send_frame("cfgbusy_next", 8'hC9, len, par);

    // Config write and byte in the same IDLE cycle
    wait_ready("simul");
    bus.c_addr   = 4'h0;
    bus.c_data   = 8'hFB;
    bus.c_valid  = 1'b1;
    bus.data     = 8'h81;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.c_valid  = 1'b0;
    bus.valid_in = 1'b0;
    m_ctrl       = 3'b011;
    check_frame("simul", 8'h81, -1, 4'h0, 8'h00, len, par, crh);
    chk("simul_parity", {31'd0, par}, 32'd1);

    // Reset in the middle of a frame
    cfg_write(4'h0, 8'h05);
    cfg_write(4'h1, 8'd1);
    wait_ready("rstmid");
    bus.data     = 8'h00;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (80) @(negedge clk);
    chk("rstmid_line_low", {31'd0, bus.tx}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_tx_busy_rdy_crdy",
        {28'd0, bus.tx, bus.busy, bus.ready_out, bus.c_ready}, 32'd11);
    rst_n   = 1'b1;
    m_ctrl  = 3'd0;
    m_presc = 8'd0;
    send_frame("after_rst", 8'h5A, len, par);

    // Random formats, prescalers and bytes, with a write to an unused address
    for (int i = 0; i < 6; i++) begin
      cfg_write(4'($urandom_range(2, 15)), 8'($urandom));
      cfg_write(4'h0, 8'($urandom_range(0, 255)));
      cfg_write(4'h1, 8'($urandom_range(0, 2)));
      rd = 8'($urandom);
      send_frame($sformatf("rnd%0d", i), rd, len, par);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
